data_mem_ctrl: RTL and testbench

- Parametrised word-organised data memory with a request/response handshake, byte/half/word access, load sign/zero extension, alignment fault detection and configurable access latency.
- Sits in the MEM stage behind the pipeline's load/store unit. A hardware clear sequence after reset zeroes the array.

---
 rtl/data_mem_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : data_mem_ctrl
// Brief  : Word-organised data memory with req/resp handshake, byte/half/word
//          access, load extension, alignment faults and post-reset clearing.
// Rev    : 1.0
// ============================================================================
module data_mem_ctrl #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault,
    output logic                  init_done
);

    localparam int             IDX_W     = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [3:0]     WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   clr_cnt;
    logic [3:0]         wait_cnt;
    logic [31:0]        mem [DEPTH];

    logic               lat_write;
    logic [1:0]         lat_size;
    logic               lat_unsigned;
    logic [IDX_W+1:0]   lat_addr;
    logic [31:0]        lat_wdata;

    logic               accept;
    logic [IDX_W-1:0]   word_idx;
    logic [1:0]         lane;
    logic [31:0]        cur_word;
    logic               fault;
    logic [7:0]         load_byte;
    logic [15:0]        load_half;
    logic [31:0]        load_val;
    logic [3:0]         byte_en;
    logic [31:0]        store_rep;
    logic [31:0]        merged;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    logic [31:0]        mem_wdata;
    logic               unused_addr;

    // Address bits above the array are aliased away by design.
    assign unused_addr = &{1'b0, req_addr};

    assign accept   = (state == S_IDLE) && req_valid;
    assign word_idx = lat_addr[IDX_W+1:2];
    assign lane     = lat_addr[1:0];
    assign cur_word = mem[word_idx];
    assign fault    = (lat_size == 2'd3) ||
                      ((lat_size == 2'd1) && lane[0]) ||
                      ((lat_size == 2'd2) && (lane != 2'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            clr_cnt   <= '0;
            wait_cnt  <= 4'd0;
            init_done <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_INIT) begin
                clr_cnt <= clr_cnt + 1'b1;
                if (clr_cnt == LAST_IDX) begin
                    init_done <= 1'b1;
                end
            end
            if (accept) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write    <= req_write;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_addr     <= req_addr[IDX_W+1:0];
            lat_wdata    <= req_wdata;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_fault = 1'b0;
        case (state)
            S_INIT: begin
                if (clr_cnt == LAST_IDX) begin
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_fault = fault;
                resp_rdata = (fault || lat_write) ? 32'd0 : load_val;
                state_next = S_IDLE;
            end
            default: state_next = S_INIT;
        endcase
    end

    always_comb begin
        load_byte = 8'd0;
        case (lane)
            2'd0:    load_byte = cur_word[7:0];
            2'd1:    load_byte = cur_word[15:8];
            2'd2:    load_byte = cur_word[23:16];
            default: load_byte = cur_word[31:24];
        endcase
        load_half = lane[1] ? cur_word[31:16] : cur_word[15:0];
        load_val  = cur_word;
        if (lat_size == 2'd0) begin
            load_val = lat_unsigned ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
        end else if (lat_size == 2'd1) begin
            load_val = lat_unsigned ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
        end
    end

    // Replicate store data across lanes so the byte enables alone pick the target.
    always_comb begin
        byte_en   = 4'b1111;
        store_rep = lat_wdata;
        if (lat_size == 2'd0) begin
            byte_en   = 4'b0001 << lane;
            store_rep = {4{lat_wdata[7:0]}};
        end else if (lat_size == 2'd1) begin
            byte_en   = lane[1] ? 4'b1100 : 4'b0011;
            store_rep = {2{lat_wdata[15:0]}};
        end
        merged = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                merged[i*8 +: 8] = store_rep[i*8 +: 8];
            end
        end
    end

    assign mem_we    = !rst && ((state == S_INIT) ||
                                ((state == S_RESP) && lat_write && !fault));
    assign mem_waddr = (state == S_INIT) ? clr_cnt : word_idx;
    assign mem_wdata = (state == S_INIT) ? 32'd0 : merged;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_data_mem_ctrl
// Brief  : Scoreboard bench for data_mem_ctrl (DEPTH=16, WAIT_STATES=3).
// Rev    : 1.0
// ============================================================================
module tb_data_mem_ctrl;

    localparam int DEPTH = 16;
    localparam int WS    = 3;
    localparam int AW    = 32;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_fault;
    logic          init_done;

    data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(WS), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .init_done    (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          due;
    } exp_t;
    exp_t sbq[$];

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every response pops one expectation, including its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected none", cyc);
            end else begin
                e = sbq.pop_front();
                check32("resp_rdata", resp_rdata, e.rdata);
                check32("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
                check32("resp_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Called at a negedge; returns the cycle number of the accepting edge.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] er, input logic ef,
                         input bit expect_resp, output int acc);
        int   n;
        exp_t e;
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got req_ready=%b expected 1", req_ready);
        end
        acc = cyc + 1;
        if (expect_resp) begin
            e.rdata = er;
            e.fault = ef;
            e.due   = acc + WS;
            sbq.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (expect_resp) begin
            n = 0;
            while (req_ready !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check32("ready_return_cycle", 32'(cyc), 32'(acc + WS + 1));
        end
    endtask

    task automatic wait_init(input int start);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check32("init_done_delay", 32'(cyc - start), 32'(DEPTH));
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int acc;
        int rel;
        int n;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        @(negedge clk);
        @(negedge clk);
        check32("rst_req_ready",  {31'd0, req_ready},  32'd0);
        check32("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check32("rst_resp_rdata", resp_rdata,          32'd0);
        check32("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        check32("rst_init_done",  {31'd0, init_done},  32'd0);
        rst = 1'b0;
        rel = cyc;
        wait_init(rel);

        // Reset clear
        issue(1, 2'd2, 0, 32'h14, 32'hDEADBEEF, 32'h0,        0, 1, acc);
        issue(0, 2'd2, 0, 32'h14, 32'h0,        32'hDEADBEEF, 0, 1, acc);
        pulse_rst();
        rel = cyc;
        wait_init(rel);
        issue(0, 2'd2, 0, 32'h14, 32'h0, 32'h00000000, 0, 1, acc);

        // Byte/half merge
        issue(1, 2'd2, 0, 32'h8, 32'h11223344, 32'h0, 0, 1, acc);
        issue(1, 2'd0, 0, 32'h9, 32'h000000AA, 32'h0, 0, 1, acc);
        issue(1, 2'd1, 0, 32'hA, 32'h0000BEEF, 32'h0, 0, 1, acc);
        issue(0, 2'd2, 0, 32'h8, 32'h0,        32'hBEEFAA44, 0, 1, acc);

        // Load extension
        issue(1, 2'd2, 0, 32'h0, 32'h8000F0FF, 32'h0, 0, 1, acc);
        issue(0, 2'd0, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 1, acc);
        issue(0, 2'd0, 1, 32'h0, 32'h0, 32'h000000FF, 0, 1, acc);
        issue(0, 2'd1, 0, 32'h2, 32'h0, 32'hFFFF8000, 0, 1, acc);
        issue(0, 2'd1, 1, 32'h2, 32'h0, 32'h00008000, 0, 1, acc);
        issue(0, 2'd0, 0, 32'h1, 32'h0, 32'hFFFFFFF0, 0, 1, acc);
        issue(0, 2'd0, 1, 32'h3, 32'h0, 32'h00000080, 0, 1, acc);
        issue(0, 2'd1, 1, 32'h0, 32'h0, 32'h0000F0FF, 0, 1, acc);

        // Faults
        issue(1, 2'd2, 0, 32'h4, 32'h12345678, 32'h0, 0, 1, acc);
        issue(1, 2'd2, 0, 32'h6, 32'hCAFEF00D, 32'h0, 1, 1, acc);
        issue(0, 2'd2, 0, 32'h4, 32'h0, 32'h12345678, 0, 1, acc);
        issue(0, 2'd1, 0, 32'h3, 32'h0, 32'h0, 1, 1, acc);
        issue(0, 2'd3, 0, 32'h0, 32'h0, 32'h0, 1, 1, acc);
        issue(1, 2'd1, 0, 32'h5, 32'hFFFF, 32'h0, 1, 1, acc);
        issue(0, 2'd2, 0, 32'h4, 32'h0, 32'h12345678, 0, 1, acc);

        // Abort during WAIT: no response, array re-zeroed
        issue(1, 2'd2, 0, 32'hC, 32'h77777777, 32'h0, 0, 0, acc);
        pulse_rst();
        rel = cyc;
        // Request held through INIT is taken on the first IDLE cycle; address wraps to word 0.
        issue(1, 2'd0, 0, 32'h40, 32'h0000005A, 32'h0, 0, 1, acc);
        check32("held_accept_cycle", 32'(acc), 32'(rel + DEPTH + 1));
        check32("init_done_after_abort", {31'd0, init_done}, 32'd1);
        issue(0, 2'd2, 0, 32'h0,  32'h0, 32'h0000005A, 0, 1, acc);
        issue(0, 2'd2, 0, 32'hC,  32'h0, 32'h00000000, 0, 1, acc);
        issue(0, 2'd2, 0, 32'h8,  32'h0, 32'h00000000, 0, 1, acc);
        issue(0, 2'd2, 0, 32'h4,  32'h0, 32'h00000000, 0, 1, acc);
        issue(0, 2'd0, 1, 32'hFFFFFF80, 32'h0, 32'h0000005A, 0, 1, acc);

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check32("scoreboard_drained", 32'(sbq.size()), 32'd0);
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected $finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
